// File: rtl/riscv_pcp_modq.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pcp_modq
//  Brief    : PCPI modular-arithmetic coprocessor for PicoRV32. Executes
//             modmul/modadd/modsub/modred modulo a runtime-programmable q
//             (plus setq/getq) with a restoring shift-subtract reducer.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_pcp_modq #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  Q_DEFAULT = XLEN'(12289),
   parameter logic [6:0]       OPCODE    = 7'b0001011,
   parameter logic [6:0]       FUNCT7    = 7'b0000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pcpi_valid,
   input  logic [31:0]     pcpi_insn,
   input  logic [XLEN-1:0] pcpi_rs1,
   input  logic [XLEN-1:0] pcpi_rs2,
   output logic            pcpi_wr,
   output logic [XLEN-1:0] pcpi_rd,
   output logic            pcpi_busy,
   output logic            pcpi_ready,
   output logic [XLEN-1:0] q_value
);

   // Iteration counter must hold 2*XLEN (modmul dividend length).
   localparam int c_ITER_W = $clog2(2*XLEN + 1);

   localparam logic [2:0] c_F3_MUL  = 3'b000;
   localparam logic [2:0] c_F3_ADD  = 3'b001;
   localparam logic [2:0] c_F3_SUB  = 3'b010;
   localparam logic [2:0] c_F3_GETQ = 3'b100;
   localparam logic [2:0] c_F3_SETQ = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PREP   = 3'd1,
      S_REDUCE = 3'd2,
      S_FIXUP  = 3'd3,
      S_DONE   = 3'd4,
      S_HOLD   = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [XLEN-1:0]       op_a_q, op_a_d;
   logic [XLEN-1:0]       op_b_q, op_b_d;
   logic [2:0]            f3_q, f3_d;
   logic [2*XLEN-1:0]     div_q, div_d;
   logic [XLEN:0]         rem_q, rem_d;
   logic [c_ITER_W-1:0]   iter_q, iter_d;
   logic                  neg_q, neg_d;
   logic [XLEN-1:0]       res_q, res_d;
   logic [XLEN-1:0]       rd_q, rd_d;
   logic                  ready_q, ready_d;
   logic                  wr_q, wr_d;
   logic                  busy_q, busy_d;
   logic [XLEN-1:0]       q_q, q_d;

   logic [2:0]            w_f3;
   logic                  w_f3_ok;
   logic                  w_claim;
   logic                  w_is_qop;
   logic [2*XLEN-1:0]     w_prod;
   logic [XLEN:0]         w_sum;
   logic                  w_lt;
   logic [XLEN-1:0]       w_diff;
   logic [XLEN:0]         w_rem_sh;
   logic                  w_rem_ge;
   logic                  w_unused_insn;

   // Register-field bits of the instruction carry no meaning for this unit.
   assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

   // Decode: funct3 101/110 are left for other coprocessors.
   assign w_f3    = pcpi_insn[14:12];
   assign w_f3_ok = (w_f3 != 3'b101) && (w_f3 != 3'b110);
   assign w_claim = pcpi_valid && (pcpi_insn[6:0] == OPCODE) &&
                    (pcpi_insn[31:25] == FUNCT7) && w_f3_ok;
   assign w_is_qop = (f3_q == c_F3_GETQ) || (f3_q == c_F3_SETQ);

   // Dividend sources, all computed from the latched operands.
   assign w_prod = {{XLEN{1'b0}}, op_a_q} * {{XLEN{1'b0}}, op_b_q};
   assign w_sum  = {1'b0, op_a_q} + {1'b0, op_b_q};
   assign w_lt   = op_a_q < op_b_q;
   assign w_diff = w_lt ? (op_b_q - op_a_q) : (op_a_q - op_b_q);

   // One restoring step: rem stays below q, so the shifted value fits W+1 bits.
   assign w_rem_sh = {rem_q[XLEN-1:0], div_q[2*XLEN-1]};
   assign w_rem_ge = w_rem_sh >= {1'b0, q_q};

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      f3_d    = f3_q;
      div_d   = div_q;
      rem_d   = rem_q;
      iter_d  = iter_q;
      neg_d   = neg_q;
      res_d   = res_q;
      rd_d    = rd_q;
      ready_d = 1'b0;
      wr_d    = 1'b0;
      busy_d  = busy_q;
      q_d     = q_q;

      case (state_q)
         S_IDLE: begin
            if (w_claim) begin
               busy_d  = 1'b1;
               op_a_d  = pcpi_rs1;
               op_b_d  = pcpi_rs2;
               f3_d    = w_f3;
               state_d = ((w_f3 == c_F3_GETQ) || (w_f3 == c_F3_SETQ)) ? S_DONE : S_PREP;
            end
         end

         S_PREP: begin
            if (!pcpi_valid) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               // Dividends are left-aligned so the reducer always consumes from the MSB.
               rem_d = '0;
               neg_d = 1'b0;
               case (f3_q)
                  c_F3_MUL: begin
                     div_d  = w_prod;
                     iter_d = c_ITER_W'(2*XLEN);
                  end
                  c_F3_ADD: begin
                     div_d  = {w_sum, {(XLEN-1){1'b0}}};
                     iter_d = c_ITER_W'(XLEN+1);
                  end
                  c_F3_SUB: begin
                     div_d  = {w_diff, {XLEN{1'b0}}};
                     neg_d  = w_lt;
                     iter_d = c_ITER_W'(XLEN);
                  end
                  default: begin
                     div_d  = {op_a_q, {XLEN{1'b0}}};
                     iter_d = c_ITER_W'(XLEN);
                  end
               endcase
               state_d = S_REDUCE;
            end
         end

         S_REDUCE: begin
            if (!pcpi_valid) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               rem_d  = w_rem_ge ? (w_rem_sh - {1'b0, q_q}) : w_rem_sh;
               div_d  = div_q << 1;
               iter_d = iter_q - c_ITER_W'(1);
               if (iter_q == c_ITER_W'(1)) begin
                  state_d = S_FIXUP;
               end
            end
         end

         S_FIXUP: begin
            if (!pcpi_valid) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               // A negative difference maps to q-rem; a zero remainder stays zero.
               res_d   = (neg_q && (rem_q != '0)) ? (q_q - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            ready_d = 1'b1;
            wr_d    = 1'b1;
            busy_d  = 1'b0;
            rd_d    = w_is_qop ? q_q : res_q;
            if ((f3_q == c_F3_SETQ) && (op_a_q >= XLEN'(2))) begin
               q_d = op_a_q;
            end
            state_d = pcpi_valid ? S_HOLD : S_IDLE;
         end

         S_HOLD: begin
            // Wait for the core to retire the instruction before claiming again.
            if (!pcpi_valid) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         f3_q    <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         iter_q  <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
         rd_q    <= '0;
         ready_q <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         q_q     <= Q_DEFAULT;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         f3_q    <= f3_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         iter_q  <= iter_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         rd_q    <= rd_d;
         ready_q <= ready_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         q_q     <= q_d;
      end
   end

   assign pcpi_wr    = wr_q;
   assign pcpi_rd    = rd_q;
   assign pcpi_busy  = busy_q;
   assign pcpi_ready = ready_q;
   assign q_value    = q_q;

endmodule
`default_nettype wire

// File: doc/riscv_pcp_modq.md
Name: riscv_pcp_modq

Overview:
Parametrised modular-arithmetic PCPI coprocessor for PicoRV32. It executes custom-0 instructions (modmul, modadd, modsub, modred) modulo a runtime-programmable modulus, with setq/getq access to that modulus. Reduction uses a sequential restoring shift-subtract unit of generic width instead of a fixed-constant divider. The block sits on the PCPI bus beside the MUL/DIV coprocessor and claims only its own opcode/funct7.

Parameters:
XLEN, 32, operand/result width W
Q_DEFAULT, 12289, modulus after reset; legal range 2..2^XLEN-1
OPCODE, 7'b0001011, claimed major opcode
FUNCT7, 7'b0000000, claimed funct7

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
pcpi_valid  in  1  instruction offered by core
pcpi_insn  in  32  instruction word
pcpi_rs1  in  XLEN  operand 1
pcpi_rs2  in  XLEN  operand 2
pcpi_wr  out  1  write rd (pulses with pcpi_ready)
pcpi_rd  out  XLEN  result
pcpi_busy  out  1  instruction claimed, in progress
pcpi_ready  out  1  result valid, 1-cycle pulse
q_value  out  XLEN  current modulus register

Behaviour:
- Reset: pcpi_wr/ready/busy=0, pcpi_rd=0, state=IDLE, q=Q_DEFAULT. Async reset mid-operation aborts with no ready.
- Claim: insn[6:0]==OPCODE && insn[31:25]==FUNCT7 && funct3 in {000,001,010,011,100,111}. funct3 101/110 are never claimed: busy stays 0.
- funct3: 000 modmul (rs1*rs2 mod q); 001 modadd ((rs1+rs2) mod q, W+1-bit sum); 010 modsub ((rs1-rs2) mod q, mathematical result in [0,q)); 011 modred (rs1 mod q); 100 getq (rd=q); 111 setq (rd=old q; q<=rs1 only if rs1>=2, else q unchanged).
- Operands and funct3 latch at the claiming edge. Later changes on rs1/rs2/insn are ignored.
- States: IDLE, PREP, REDUCE, FIXUP, DONE, HOLD.
- IDLE: on claim (edge E0), busy<=1 and go to PREP. getq/setq instead go to DONE directly (ready after edge E0+1).
- PREP (edge E0+1): register the dividend and set iter=N. Dividend: modmul = 2W-bit product, N=2W; modadd = W+1-bit sum, N=W+1; modsub = |rs1-rs2|, N=W, with neg flag = rs1<rs2; modred = rs1, N=W. Clear rem (W+1 bits).
- REDUCE: one step per edge: rem={rem[W-1:0],dividend MSB}, dividend<<=1; if rem>=q then rem-=q; iter--. Leave when iter reaches 0, after exactly N edges.
- FIXUP: result = (neg && rem!=0) ? q-rem : rem.
- DONE: pcpi_ready=1, pcpi_wr=1, pcpi_busy=0, pcpi_rd=result for exactly one cycle. pcpi_rd holds its value afterwards.
- Latency: ready is visible after edge E0+N+3 (modmul XLEN=32: 67 edges; modadd: 36; modsub/modred: 35).
- After DONE: next state HOLD if pcpi_valid is still high, else IDLE. HOLD returns to IDLE when valid is low, which prevents re-claiming the same instruction.
- Abort: pcpi_valid low in PREP/REDUCE/FIXUP gives IDLE at the next edge, busy<=0, no ready/wr, and q is unchanged.
- setq takes effect at its DONE edge. An operation already in flight is not possible (single issue).
- Operand ranges: inputs need not be reduced. All results are in [0,q-1]. Any q in 2..2^W-1 is correct.

Test Plan:
1. XLEN=32, q=12289; modmul rs1=12288 rs2=12288 -> rd=1, wr=ready=1 for exactly one cycle at E0+67, busy high E0+1..E0+66.
2. modadd 12288+5 -> 4. modadd 0xFFFFFFFF+1 -> 10952 (carry bit retained). modred 0xFFFFFFFF -> 10951.
3. modsub 3-10 -> 12282. modsub 10-3 -> 7. modsub 5-5 -> 0 (no fixup to q).
4. setq rs1=17 -> rd=12289 and q_value=17; then modred 100 -> 15. setq rs1=1 -> rd=17, q stays 17. getq -> 17 after 2 edges.
5. Start modmul, drop valid at edge E0+10 -> busy=0 next edge, no ready. Next modadd 1+2 completes with rd=3. Hold valid high 3 cycles after ready -> no second claim.
6. Assert reset during REDUCE -> outputs 0 immediately, q_value=12289. funct3=101 or funct7=0000001 -> busy=0 and ready=0 for 100 cycles.
